// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with a local word-addressed data memory.
// Define MEM_STAGE_FAST_LOAD_EN for single-cycle loads (stall tied low).
module mem_stage #(
  parameter int ADDR_W   = 10,
  parameter int LOAD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] m_IR,
  input  logic [31:0] saida,
  input  logic [9:0]  mem_dest,
  output logic        stall,
  output logic [31:0] w_IR,
  output logic [31:0] saidaULA_wb,
  output logic [4:0]  wb_reg,
  output logic        wb_en
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic [31:0] mem [2**ADDR_W];

  logic [5:0]        op;
  logic              accept;
  logic              is_r, is_addi, is_lw, is_sw;
  logic [ADDR_W-1:0] ld_addr, st_addr;
  logic [31:0]       d_ir, d_val;
  logic [4:0]        d_reg;
  logic              d_wr, d_en;

  assign op      = m_IR[31:26];
  assign is_r    = accept && (op == OP_R);
  assign is_addi = accept && (op == OP_ADDI);
  assign is_lw   = accept && (op == OP_LW);
  assign is_sw   = accept && (op == OP_SW);
  assign ld_addr = saida[ADDR_W-1:0];
  assign st_addr = ADDR_W'(mem_dest);

  always_comb begin
    d_ir  = '0;
    d_val = '0;
    d_reg = '0;
    d_wr  = 1'b0;
    unique case (1'b1)
      is_r: begin
        d_ir  = m_IR;
        d_val = saida;
        d_reg = m_IR[15:11];
        d_wr  = 1'b1;
      end
      is_addi: begin
        d_ir  = m_IR;
        d_val = saida;
        d_reg = m_IR[20:16];
        d_wr  = 1'b1;
      end
      is_lw: begin
        d_ir  = m_IR;
        d_val = mem[ld_addr];
        d_reg = mem_dest[4:0];
        d_wr  = 1'b1;
      end
      is_sw: d_ir = m_IR;
      default: ;
    endcase
  end

  assign d_en = d_wr && (d_reg != 5'd0);

  // Memory has no reset so contents survive a pipeline reset.
  always_ff @(posedge clock) begin
    if (is_sw) mem[st_addr] <= saida;
  end

`ifdef MEM_STAGE_FAST_LOAD_EN

  assign accept = reset && in_valid;
  assign stall  = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_IR        <= '0;
      saidaULA_wb <= '0;
      wb_reg      <= '0;
      wb_en       <= 1'b0;
    end else begin
      w_IR        <= d_ir;
      saidaULA_wb <= d_val;
      wb_reg      <= d_reg;
      wb_en       <= d_en;
    end
  end

`else

  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit MULTI = (LOAD_LAT > 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [4:0]        lat_reg;
  logic [31:0]       lat_ir;

  assign stall  = (state == WAIT);
  assign accept = reset && in_valid && !stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_reg     <= '0;
      lat_ir      <= '0;
      w_IR        <= '0;
      saidaULA_wb <= '0;
      wb_reg      <= '0;
      wb_en       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_lw && MULTI) begin
            state       <= WAIT;
            cnt         <= 4'(LOAD_LAT - 1);
            lat_addr    <= ld_addr;
            lat_reg     <= mem_dest[4:0];
            lat_ir      <= m_IR;
            w_IR        <= '0;
            saidaULA_wb <= '0;
            wb_reg      <= '0;
            wb_en       <= 1'b0;
          end else begin
            w_IR        <= d_ir;
            saidaULA_wb <= d_val;
            wb_reg      <= d_reg;
            wb_en       <= d_en;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state       <= IDLE;
            cnt         <= '0;
            w_IR        <= lat_ir;
            saidaULA_wb <= mem[lat_addr];
            wb_reg      <= lat_reg;
            wb_en       <= (lat_reg != 5'd0);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute ALU. Consumes the ALU result (`saida`), the address/destination field (`mem_dest`) and the in-flight instruction (`m_IR`), performs loads and stores against a local word-addressed data memory, and registers the write-back triple (`w_IR`, `saidaULA_wb`, destination) that feeds the register file and the ALU's forwarding inputs. Loads take a configurable multi-cycle latency and stall upstream stages while in progress.

## Interface
- `ADDR_W`, 10, word-address width; memory depth is 2^ADDR_W words.
- `LOAD_LAT`, 2, load latency in cycles (1..15); 1 means no stall.
- `clock`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `m_IR`/`saida`/`mem_dest` hold a real instruction.
- `m_IR`  in  32  instruction in this stage.
- `saida`  in  32  ALU result: R-type/addi value, load address, or store data.
- `mem_dest`  in  10  load: rt index in [4:0]; store: word address.
- `stall`  out  1  load in progress; upstream must hold its registers.
- `w_IR`  out  32  instruction passed to write-back (0 on bubble).
- `saidaULA_wb`  out  32  write-back value.
- `wb_reg`  out  5  destination register.
- `wb_en`  out  1  register-file write enable.

## Operation
- Decode on `m_IR[31:26]` when `in_valid=1` and `stall=0`:
  - `000000` R-type: `wb_reg=m_IR[15:11]`, value `saida`, `wb_en=1`.
  - `001000` addi: `wb_reg=m_IR[20:16]`, value `saida`, `wb_en=1`.
  - `100011` lw: address `saida[ADDR_W-1:0]`, `wb_reg=mem_dest[4:0]`, value = memory word, `wb_en=1`; enters load FSM.
  - `101011` sw: `mem[mem_dest] <= saida` at the accepting edge; `wb_en=0`, `w_IR=m_IR`.
  - Any other opcode, or `in_valid=0`: bubble (`w_IR=0`, `wb_en=0`, `wb_reg=0`, value 0).
- `wb_en` is forced 0 whenever the destination is register 0.
- Load FSM states: IDLE, WAIT. IDLE accepting lw with `LOAD_LAT>1`: latch address/`wb_reg`/`m_IR`, counter <= `LOAD_LAT-1`, go WAIT. WAIT: decrement each edge; at the edge where counter reaches 0, register read data and write-back fields, return IDLE.
- `stall = (state==WAIT)`; inputs are ignored in WAIT.
- Memory is not cleared by reset; contents persist across reset.
- Memory write happens at the sw accepting edge; a lw accepted on the next edge reads the new value (no extra hazard logic).
- Upper `saida` bits above ADDR_W are ignored (wrap-around within memory).

## Timing
- Reset (asynchronous, `reset=0`): `stall=0`, `w_IR=0`, `saidaULA_wb=0`, `wb_reg=0`, `wb_en=0`, FSM IDLE, counter 0; effective immediately, not waiting for a clock edge.
- Non-load accepted at edge N: outputs valid after edge N (1-cycle latency).
- Load accepted at edge N, `LOAD_LAT=L`: outputs show bubble after edge N..N+L-2; load result valid after edge N+L-1; `stall` high from after edge N to edge N+L-1 (L-1 cycles).
- `LOAD_LAT=1`: load behaves like non-load, `stall` never asserts.
- Reset during WAIT: FSM aborts, pending load discarded, no write-back.

## Configuration
- `MEM_STAGE_FAST_LOAD_EN` defined: load FSM compiled out; every load completes in 1 cycle, `stall` tied 0, `LOAD_LAT` ignored.
- Not defined: multi-cycle load FSM and `stall` as described above.

## Test plan
- Reset pulse mid-run -> all outputs 0, `stall=0` asynchronously before next edge.
- sw `mem_dest=5`, `saida=32'hDEADBEEF`; then lw `mem_dest=3`, `saida=5` (LOAD_LAT=2) -> `stall` high exactly 1 cycle, then `wb_reg=3`, `saidaULA_wb=32'hDEADBEEF`, `wb_en=1`.
- R-type add `m_IR[15:11]=7`, `saida=32'h10` -> next cycle `wb_reg=7`, `saidaULA_wb=32'h10`, `wb_en=1`, `w_IR=m_IR`.
- addi with rt=0, `saida=32'h55` -> `wb_en=0`.
- lw accepted, `reset` asserted during `stall` -> `stall=0`, no write-back; after release, lw address 5 still returns `32'hDEADBEEF`.
- Opcode `000010`, or `in_valid=0` -> bubble: `w_IR=0`, `wb_en=0`.
